// File: rtl/etherparse_axis_pkg.sv
// Shared definitions for the AXI-Stream frame path.
//   TUSER_DROP_BIT : position of the frame-bad flag in tuser
//   count_t        : width of the frame/drop statistics counters
package etherparse_axis_pkg;

    localparam int TUSER_DROP_BIT = 0;
    localparam int COUNT_WIDTH    = 32;

    typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/axis_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register only updates when rd_en is high, so it can serve
// directly as a holding output register.
// Ports:
//   clk, rst_n            clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr         read request
//   rd_data               registered read data (0 out of reset)
module axis_sdp_ram #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_drop_fifo.sv
// Store-and-forward AXI-Stream frame FIFO. A frame becomes visible
// downstream only after its last beat is stored without an error mark;
// frames marked bad in tuser, or that overflow the buffer, are dropped.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast/s_tuser  input stream (never stalls)
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser  output stream (tuser always 0)
//   drop_count   frames discarded since reset
//   frame_count  frames fully delivered downstream
module axis_drop_fifo
    import etherparse_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    output count_t                drop_count,
    output count_t                frame_count
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   commit_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   fill;
    logic               full;
    logic               bad;
    logic               beat_acc;
    logic               beat_bad;
    logic               drop_frame;
    logic               wr_en;
    logic               rd_en;
    logic               committed_avail;
    logic [ENTRY_W-1:0] rd_entry;
    logic               unused_user;

    // Never backpressure; readiness simply follows reset.
    assign s_tready = rst_n;
    assign m_tuser  = '0;

    // Only the drop flag bit is meaningful on the input sideband.
    assign unused_user = ^s_tuser;

    // Occupancy counts uncommitted beats too, so a frame that will not
    // fit overflows and is dropped instead of stalling the input.
    assign fill     = wr_ptr - rd_ptr;
    assign full     = (fill == PTR_W'(DEPTH));
    assign beat_acc = s_tvalid & s_tready;
    assign beat_bad = s_tuser[TUSER_DROP_BIT];

    assign drop_frame = beat_acc & s_tlast & (bad | beat_bad | full);
    assign wr_en      = beat_acc & ~full & ~bad & ~beat_bad;

    // Write side: store beats, then either commit or rewind on tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            bad        <= 1'b0;
            drop_count <= '0;
        end else if (beat_acc) begin
            if (s_tlast) begin
                bad <= 1'b0;
                if (drop_frame) begin
                    wr_ptr     <= commit_ptr;
                    drop_count <= drop_count + count_t'(1);
                end else begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    commit_ptr <= wr_ptr + 1'b1;
                end
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (beat_bad || full) begin
                    bad <= 1'b1;
                end
            end
        end
    end

    // Read side: the RAM read register is the output register. It loads
    // whenever it is empty or being consumed and a committed beat waits.
    assign committed_avail = (rd_ptr != commit_ptr);
    assign rd_en           = committed_avail & (~m_tvalid | m_tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            m_tvalid    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr   <= rd_ptr + 1'b1;
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (m_tvalid && m_tready && m_tlast) begin
                frame_count <= frame_count + count_t'(1);
            end
        end
    end

    axis_sdp_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_entry)
    );

    assign {m_tlast, m_tdata} = rd_entry;

endmodule

// File: tb/tb_axis_drop_fifo.sv
// Self-checking bench for axis_drop_fifo: a frame-level model (queue of
// expected good beats, drop/frame tallies) checked every cycle, plus
// directed literal expectations.
module tb_axis_drop_fifo;
    import etherparse_axis_pkg::*;

    localparam int DW    = 64;
    localparam int UW    = 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    count_t        drop_count;
    count_t        frame_count;

    always #5 clk = ~clk;

    axis_drop_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .drop_count  (drop_count),
        .frame_count (frame_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [64:0] exp_q[$];
    logic [64:0] cur_frame[$];
    bit          cur_bad;
    bit          in_frame;
    int          cur_free;
    count_t      exp_drop;
    count_t      exp_frames;
    bit          hold_prev;
    logic [64:0] hold_val;

    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst_n) begin
            exp_q.delete();
            cur_frame.delete();
            cur_bad    = 1'b0;
            in_frame   = 1'b0;
            exp_drop   = '0;
            exp_frames = '0;
            hold_prev  = 1'b0;
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_drop_count", drop_count, 0);
            chk("rst_frame_count", frame_count, 0);
        end else begin
            chk("drop_count", drop_count, exp_drop);
            chk("frame_count", frame_count, exp_frames);
            chk("s_tready", s_tready, 1);
            chk("m_tuser", m_tuser, 0);
            if (hold_prev) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_beat", {m_tlast, m_tdata}, hold_val);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {m_tlast, m_tdata}, e);
                    if (e[64]) exp_frames++;
                end
            end
            hold_prev = m_tvalid && !m_tready;
            hold_val  = {m_tlast, m_tdata};
            if (s_tvalid && s_tready) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_free = DEPTH - exp_q.size();
                end
                cur_frame.push_back({s_tlast, s_tdata});
                if (s_tuser[0]) cur_bad = 1'b1;
                if (s_tlast) begin
                    if (cur_bad || cur_frame.size() > cur_free) begin
                        exp_drop++;
                    end else begin
                        foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
                    end
                    cur_frame.delete();
                    cur_bad  = 1'b0;
                    in_frame = 1'b0;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    bit rnd_ready = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) m_tready = ($urandom_range(3) != 0);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input logic bad);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = bad;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!m_tvalid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", m_tvalid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] lit [4];
        int good_planned;
        int bad_planned;
        int len;
        int bidx;
        int n;
        bit fbad;

        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        m_tready = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_m_tdata", m_tdata, 0);
        chk("reset_m_tlast", m_tlast, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single 3-beat frame, latency and streaming
        send_beat(64'h11, 1'b0, 1'b0);
        send_beat(64'h22, 1'b0, 1'b0);
        send_beat(64'h33, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_not_yet_valid", m_tvalid, 0);
        @(negedge clk);
        chk("t1_valid", m_tvalid, 1);
        chk("t1_beat0", {m_tlast, m_tdata}, {1'b0, 64'h11});
        @(negedge clk);
        chk("t1_beat1", {m_tlast, m_tdata}, {1'b0, 64'h22});
        @(negedge clk);
        chk("t1_beat2", {m_tlast, m_tdata}, {1'b1, 64'h33});
        @(negedge clk);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_idle", m_tvalid, 0);
        @(posedge clk);
        #1;

        // bad-marked frame dropped, following frame passes
        send_beat(64'h41, 1'b0, 1'b0);
        send_beat(64'h42, 1'b0, 1'b1);
        send_beat(64'h43, 1'b0, 1'b0);
        send_beat(64'h44, 1'b1, 1'b0);
        send_beat(64'hAA, 1'b1, 1'b0);
        wait_valid(20);
        chk("t2_first_out", {m_tlast, m_tdata}, {1'b1, 64'hAA});
        drain(50);
        @(negedge clk);
        chk("t2_drop_count", drop_count, 1);
        chk("t2_frame_count", frame_count, 2);
        @(posedge clk);
        #1;

        // oversize frame dropped, full-depth frame passes
        for (int i = 0; i < 20; i++) send_beat(64'h300 + 64'(i), i == 19, 1'b0);
        @(negedge clk);
        chk("t3_drop_count", drop_count, 2);
        chk("t3_no_output", m_tvalid, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_beat(64'h400 + 64'(i), i == 15, 1'b0);
        drain(100);
        @(negedge clk);
        chk("t3_frame_count", frame_count, 3);
        @(posedge clk);
        #1;

        // stalled output, then contiguous release
        m_tready = 1'b0;
        send_beat(64'hC1, 1'b0, 1'b0);
        send_beat(64'hC2, 1'b1, 1'b0);
        send_beat(64'hD1, 1'b0, 1'b0);
        send_beat(64'hD2, 1'b1, 1'b0);
        repeat (6) step();
        @(negedge clk);
        chk("t4_stalled_valid", m_tvalid, 1);
        chk("t4_stalled_data", m_tdata, 64'hC1);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        lit[0] = 64'hC1;
        lit[1] = 64'hC2;
        lit[2] = 64'hD1;
        lit[3] = 64'hD2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stream_valid", m_tvalid, 1);
            chk("t4_stream_data", m_tdata, lit[i]);
        end
        @(negedge clk);
        chk("t4_frame_count", frame_count, 5);
        @(posedge clk);
        #1;

        // reset mid-flight
        m_tready = 1'b0;
        send_beat(64'h51, 1'b0, 1'b0);
        send_beat(64'h52, 1'b0, 1'b0);
        send_beat(64'h53, 1'b1, 1'b0);
        step();
        step();
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        send_beat(64'h61, 1'b0, 1'b0);
        send_beat(64'h62, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", m_tvalid, 0);
        chk("t5_rst_data", {m_tlast, m_tdata}, 0);
        chk("t5_rst_drop", drop_count, 0);
        chk("t5_rst_frames", frame_count, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        send_beat(64'hBEEF, 1'b1, 1'b0);
        wait_valid(20);
        chk("t5_beef", {m_tlast, m_tdata}, {1'b1, 64'hBEEF});
        drain(50);
        @(negedge clk);
        chk("t5_frame_count", frame_count, 1);
        chk("t5_drop_count", drop_count, 0);
        @(posedge clk);
        #1;

        // random frames with random downstream readiness
        good_planned = 0;
        bad_planned  = 0;
        rnd_ready    = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len  = $urandom_range(6, 1);
            fbad = ($urandom_range(3) == 0);
            bidx = $urandom_range(len - 1, 0);
            n = 0;
            while (exp_q.size() + len > DEPTH && n < 300) begin
                step();
                n++;
            end
            for (int b = 0; b < len; b++) begin
                send_beat(64'h1000 + 64'(f * 16 + b), b == len - 1, fbad && b == bidx);
                if ($urandom_range(3) == 0) step();
            end
            if (fbad) bad_planned++;
            else good_planned++;
        end
        rnd_ready = 1'b0;
        m_tready  = 1'b1;
        drain(400);
        @(negedge clk);
        chk("t6_frame_count", frame_count, 64'(good_planned + 1));
        chk("t6_drop_count", drop_count, 64'(bad_planned));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
